// File: rtl/sp_align_ctrl_pkg.sv
// rtl/sp_align_ctrl_pkg.sv - shared lane alignment state encodings and defaults
package sp_align_ctrl_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        COUNT  = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    localparam logic [7:0] COMMA_DEFAULT     = 8'hBC;
    localparam int         COMMA_CNT_DEFAULT = 4;

endpackage

// File: rtl/sp_shift_reg.sv
// rtl/sp_shift_reg.sv - 8-bit MSB-first serial shifter with comma match flag
module sp_shift_reg #(
    parameter logic [7:0] COMMA = 8'hBC
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       data_in,
    output logic [7:0] sr,
    output logic       match
);

    // Shift one serial bit in every edge, oldest bit ends up in the MSB
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            sr <= 8'h00;
        end else begin
            sr <= {sr[6:0], data_in};
        end
    end

    assign match = (sr == COMMA);

endmodule

// File: rtl/sp_align_ctrl.sv
// rtl/sp_align_ctrl.sv - per-lane comma hunt, byte lock and parallel byte output
module sp_align_ctrl
    import sp_align_ctrl_pkg::*;
#(
    parameter logic [7:0] COMMA     = COMMA_DEFAULT,
    parameter int         COMMA_CNT = COMMA_CNT_DEFAULT
) (
    input  logic       clk_8f,
    input  logic       reset,
    input  logic       data_in,
    input  logic       resync,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic       sync_err
);

    localparam logic [3:0] CNT_TGT = 4'(COMMA_CNT);

    logic [7:0] sr;
    logic       match;
    state_t     state, state_d;
    logic [2:0] bit_cnt, bit_cnt_d;
    logic [3:0] comma_cnt, comma_cnt_d;
    logic [7:0] data_d;
    logic       valid_d, err_d, active_d, byte_done;

    sp_shift_reg #(.COMMA(COMMA)) u_shift (
        .clk_8f  (clk_8f),
        .reset   (reset),
        .data_in (data_in),
        .sr      (sr),
        .match   (match)
    );

    // sr holds a whole aligned byte only when the counter has wrapped to zero
    assign byte_done = (state != HUNT) && (bit_cnt == 3'd0);

    // Register FSM state, counters and all outputs
    always_ff @(posedge clk_8f or negedge reset) begin
        if (!reset) begin
            state     <= HUNT;
            bit_cnt   <= 3'd0;
            comma_cnt <= 4'd0;
            data_out  <= 8'h00;
            valid_out <= 1'b0;
            active    <= 1'b0;
            sync_err  <= 1'b0;
        end else begin
            state     <= state_d;
            bit_cnt   <= bit_cnt_d;
            comma_cnt <= comma_cnt_d;
            data_out  <= data_d;
            valid_out <= valid_d;
            active    <= active_d;
            sync_err  <= err_d;
        end
    end

    // Next state, counter updates and output strobes; resync outranks byte_done
    always_comb begin
        state_d     = state;
        bit_cnt_d   = bit_cnt;
        comma_cnt_d = comma_cnt;
        data_d      = data_out;
        valid_d     = 1'b0;
        err_d       = 1'b0;
        case (state)
            HUNT: begin
                bit_cnt_d = 3'd0;
                if (match) begin
                    comma_cnt_d = 4'd1;
                    bit_cnt_d   = 3'd1;
                    state_d     = (CNT_TGT == 4'd1) ? ACTIVE : COUNT;
                end
            end
            COUNT: begin
                if (resync) begin
                    state_d     = HUNT;
                    comma_cnt_d = 4'd0;
                    bit_cnt_d   = 3'd0;
                end else if (byte_done && !match) begin
                    state_d     = HUNT;
                    comma_cnt_d = 4'd0;
                    bit_cnt_d   = 3'd0;
                    err_d       = 1'b1;
                end else begin
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (byte_done) begin
                        if (comma_cnt + 4'd1 >= CNT_TGT) begin
                            comma_cnt_d = CNT_TGT;
                            state_d     = ACTIVE;
                        end else begin
                            comma_cnt_d = comma_cnt + 4'd1;
                        end
                    end
                end
            end
            ACTIVE: begin
                if (resync) begin
                    state_d     = HUNT;
                    comma_cnt_d = 4'd0;
                    bit_cnt_d   = 3'd0;
                end else begin
                    bit_cnt_d = bit_cnt + 3'd1;
                    if (byte_done && !match) begin
                        data_d  = sr;
                        valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d     = HUNT;
                comma_cnt_d = 4'd0;
                bit_cnt_d   = 3'd0;
            end
        endcase
        active_d = (state_d == ACTIVE);
    end

endmodule
